uart_rx_buf: RTL
================

# uart_rx_buf

Buffered UART receiver sitting between the board's `UART_RX` pin and the SoC's receive path. It:
- synchronises the asynchronous serial line;
- oversamples it at 16× the baud rate and deframes 8N1 characters;
- queues received bytes in a small first-word-fall-through FIFO drained through a valid/ready interface.

Framing errors and overruns are reported as single-cycle pulses so the SoC side can count or latch them.

## Interface
- `CLK_FREQ`, default 100000000: input clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 16: receive queue depth; must be a power of two, at least 2.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rxd` input 1: raw serial line, asynchronous, idle high.
- `rd_data` output 8: head-of-queue byte; valid only while `rd_valid`=1.
- `rd_valid` output 1: queue non-empty.
- `rd_ready` input 1: consumer accepts `rd_data`; a pop occurs on `rd_valid && rd_ready`.
- `level` output $clog2(FIFO_DEPTH)+1: bytes currently queued, 0..FIFO_DEPTH.
- `frame_err` output 1: one-cycle pulse when a stop bit samples low.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped because the queue is full.

## Operation
- **Synchroniser:** 2-flop synchroniser `rxd` → `rxd_s`; both flops reset to 1.
- **Oversample divider:**
  - `DIV = CLK_FREQ/(16*BAUD)`, integer truncation, forced to at least 1. The default is 54.
  - Free-running counter generates `tick`, one cycle every `DIV` clocks.
  - The counter restarts at 0 on the cycle a start edge is detected, so sampling phase is aligned to the edge.
- **`armed` flag:**
  - Set when `rxd_s`=1 is sampled in IDLE.
  - Cleared on a frame error.
  - A start is only recognised while `armed`, so a held-low line (break) cannot produce repeated frames.
- **FSM** with a 4-bit tick counter `sc` and a 3-bit bit index `bi`:
  - IDLE: if `armed` and `rxd_s`=0 → START, `sc`=0.
  - START: on each tick `sc`++. At `sc`=7 (mid start bit):
    - `rxd_s`=0 → DATA, with `sc`=0 and `bi`=0;
    - `rxd_s`=1 → IDLE; this is a glitch and no error is flagged.
  - DATA: on each tick `sc`++. At `sc`=15 (mid bit):
    - shift `rxd_s` into the shift register, LSB first;
    - if `bi`=7 → STOP, otherwise `bi`++.
  - STOP: at `sc`=15 (mid stop bit):
    - `rxd_s`=1 → push the byte, then IDLE;
    - `rxd_s`=0 → pulse `frame_err`, discard the byte, clear `armed`, then IDLE.
- **Push rules:**
  - A push is accepted if the queue is not full, or if a pop occurs in the same cycle.
  - Otherwise pulse `overrun`; the queue is left unchanged and the new byte is lost.
- **FIFO:**
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH)+1 bits; wrap uses the MSB.
  - `level` = `wptr − rptr`.
  - Simultaneous push and pop leaves `level` unchanged.
  - A pop while empty is ignored.
  - `rd_data` is first-word-fall-through and reflects the head entry combinationally from storage.

## Timing
- **Reset values:**
  - `rd_valid`=0, `level`=0, `frame_err`=0, `overrun`=0;
  - `rd_data` = don't-care (drive 0);
  - FSM in IDLE, `armed`=0, pointers 0.
- **Reset mid-frame:** the partial byte is discarded. Queued bytes are flushed.
- **Input latency:** falling edge on `rxd` to `rxd_s` low is 2 cycles, plus up to 1 cycle of detect.
- **Sample point:** data bit n is sampled (8 + 16·(n+1))·DIV cycles after start detect, i.e. mid-bit.
- **Output latency:** `rd_valid` rises (first byte into an empty queue) and `level` increments on the cycle after the stop-bit sample tick. `frame_err` and `overrun` assert on that same cycle, for exactly one cycle.
- **Pop:** `rd_valid`/`rd_data`/`level` update on the cycle after the pop; there is no bubble between back-to-back pops.
- **Throughput:** sustained reception at full `BAUD` with zero idle between frames. IDLE re-arms within the stop bit, so the next start edge is caught.

## Structure
- State encodings (IDLE/START/DATA/STOP) are local to `uart_rx_buf`.
- The oversample factor 16 lives in a shared UART header, common with the transmit side.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH), providing push/pop/full/empty/level with first-word-fall-through read. The FSM, divider and synchroniser stay in the top level.

## Test plan
Default parameters: bit period 864 clocks.
1. Send 0xA5 in 8N1 with `rd_ready`=0 → cycle after stop-mid tick: `rd_valid`=1, `rd_data`=0xA5, `level`=1. Then `rd_ready`=1 for one cycle → `rd_valid`=0, `level`=0.
2. `rxd` low for 3×54 clocks, then high → FSM returns to IDLE; no byte, no `frame_err`.
3. Send 0x3C with the stop bit driven low → one `frame_err` pulse, `level` unchanged. Then hold the line high for 1 bit and send 0x5A → received correctly.
4. 17 bytes 0x00..0x10 with `rd_ready`=0 → `level`=16, one `overrun` pulse on the 17th. Draining yields 0x00..0x0F in order.
5. Back-to-back frames 0x00, 0xFF, 0x81 with no idle, `rd_ready`=1 → all three delivered in order, `level` never exceeds 1.
6. Assert `rst` during bit 4 of a frame while 2 bytes are queued → `rd_valid`=0 and `level`=0 after reset. A subsequent clean 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_buf_pkg.sv
// rtl/uart_rx_buf_pkg.sv - shared UART constants and baud divider helper
package uart_rx_buf_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    // Clocks per oversample tick; truncates and never returns less than 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned d;
        d = clk_freq / (OVERSAMPLE * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with level output
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;

    // A pop frees the head slot this cycle, so a push into a full queue is still legal.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

    assign pop_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_buf.sv
// rtl/uart_rx_buf.sv - 16x oversampled 8N1 UART receiver with FWFT receive queue
module uart_rx_buf
    import uart_rx_buf_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic           rxd_m_q, rxd_s_q;
    logic [DCW-1:0] div_q, div_d;
    logic [1:0]     state_q, state_d;
    logic [3:0]     sc_q, sc_d;
    logic [2:0]     bi_q, bi_d;
    logic [7:0]     shift_q, shift_d;
    logic           armed_q, armed_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
    logic           tick, start_det, push, pop, fifo_full, fifo_empty;

    assign tick      = (div_q == DIV_LAST);
    assign start_det = (state_q == S_IDLE) && armed_q && !rxd_s_q;
    assign pop       = rd_valid && rd_ready;

    always_comb begin
        div_d       = (start_det || tick) ? '0 : div_q + DCW'(1);
        state_d     = state_q;
        sc_d        = sc_q;
        bi_d        = bi_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rxd_s_q) armed_d = 1'b1;
                if (start_det) begin
                    state_d = S_START;
                    sc_d    = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd7) begin
                        sc_d    = 4'd0;
                        bi_d    = 3'd0;
                        state_d = rxd_s_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        shift_d = {rxd_s_q, shift_q[7:1]};
                        if (bi_q == 3'd7) state_d = S_STOP;
                        else              bi_d    = bi_q + 3'd1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        state_d = S_IDLE;
                        if (rxd_s_q) begin
                            push = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            armed_d     = 1'b0;
                        end
                    end
                end
            end
        endcase
        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            div_q       <= '0;
            state_q     <= S_IDLE;
            sc_q        <= 4'd0;
            bi_q        <= 3'd0;
            shift_q     <= 8'd0;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_m_q     <= rxd;
            rxd_s_q     <= rxd_m_q;
            div_q       <= div_d;
            state_q     <= state_d;
            sc_q        <= sc_d;
            bi_q        <= bi_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (pop),
        .pop_data_o  (rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    assign rd_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
